// File: rtl/serial_twos_complementer_pkg.sv
// Shared types and constants for the bit-serial two's-complement negate/abs unit.
package twos_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_NEG = 1'b0;
    localparam logic MODE_ABS = 1'b1;

    // Negate always inverts above the first 1; abs only does so for negative operands.
    function automatic logic invert_enable(input logic mode, input logic msb);
        return (mode == MODE_NEG) | ((mode == MODE_ABS) & msb);
    endfunction

endpackage

// File: rtl/serial_twos_complementer_if.sv
// Operand/result handshake bundle for serial_twos_complementer.
interface serial_twos_complementer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             In_valid;
    logic             In_ready;
    logic [WIDTH-1:0] In;
    logic             Mode;
    logic             Out_valid;
    logic             Out_ready;
    logic [WIDTH-1:0] Out;
    logic             Ovf;

    modport master (
        output In_valid, In, Mode, Out_ready,
        input  In_ready, Out_valid, Out, Ovf
    );

    modport slave (
        input  In_valid, In, Mode, Out_ready,
        output In_ready, Out_valid, Out, Ovf
    );
endinterface

// File: rtl/serial_twos_complementer_bit_cell.sv
// One bit of the serial complement: copy up to and including the first 1, invert afterwards.
module twos_bit_cell (
    input  logic i_bit_in,
    input  logic i_seen_one,
    input  logic i_invert_en,
    output logic o_bit_out_c,
    output logic o_seen_one_next_c
);

    assign o_bit_out_c       = i_bit_in ^ (i_invert_en & i_seen_one);
    assign o_seen_one_next_c = i_seen_one | i_bit_in;

endmodule

// File: rtl/serial_twos_complementer.sv
// Bit-serial two's-complement negate / absolute value, LSB first, one bit per clock.
// Define TWOS_SAT_EN to saturate the overflow case to max positive instead of wrapping.
module serial_twos_complementer
    import twos_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic                       clk,
    input logic                       rst,
    serial_twos_complementer_if.slave bus
);

    localparam int unsigned       CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
`ifdef TWOS_SAT_EN
    localparam logic [WIDTH-1:0]  SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_out;
    logic [CNT_W-1:0] r_cnt;
    logic             r_seen_one;
    logic             r_mode;
    logic             r_msb;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_ovf;

    logic             w_invert_en;
    logic             w_bit_out;
    logic             w_seen_one_next;
    logic             w_last_ovf;
    logic [WIDTH-1:0] w_result;

    assign w_invert_en = invert_enable(r_mode, r_msb);

    twos_bit_cell u_bit_cell (
        .i_bit_in          (r_shift[0]),
        .i_seen_one        (r_seen_one),
        .i_invert_en       (w_invert_en),
        .o_bit_out_c       (w_bit_out),
        .o_seen_one_next_c (w_seen_one_next)
    );

    // Result bits enter at the top so the finished word lands LSB-aligned.
    assign w_result   = {w_bit_out, r_shift[WIDTH-1:1]};
    // On the final bit: a set MSB with no earlier 1 means the operand was 100..0.
    assign w_last_ovf = w_invert_en & r_msb & ~r_seen_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_out       <= '0;
            r_cnt       <= '0;
            r_seen_one  <= 1'b0;
            r_mode      <= MODE_NEG;
            r_msb       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.In_valid && r_in_ready) begin
                        r_shift    <= bus.In;
                        r_mode     <= bus.Mode;
                        r_msb      <= bus.In[WIDTH-1];
                        r_cnt      <= '0;
                        r_seen_one <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shift    <= w_result;
                    r_seen_one <= w_seen_one_next;
                    r_cnt      <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_ovf       <= w_last_ovf;
`ifdef TWOS_SAT_EN
                        r_out       <= w_last_ovf ? SAT_MAX : w_result;
`else
                        r_out       <= w_result;
`endif
                    end
                end
                DONE: begin
                    if (bus.Out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.In_ready  = r_in_ready;
    assign bus.Out_valid = r_out_valid;
    assign bus.Out       = r_out;
    assign bus.Ovf       = r_ovf;

endmodule

// File: tb/tb_serial_twos_complementer.sv
// Self-checking bench for serial_twos_complementer (WIDTH=8), honours TWOS_SAT_EN.
module tb_serial_twos_complementer;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    serial_twos_complementer_if #(.WIDTH(W)) bus ();

    serial_twos_complementer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed arithmetic on the operand value, then fold into 8 bits.
    function automatic logic [W-1:0] model_out(input logic [W-1:0] x, input logic m);
        int v;
        int r;
        v = $signed(x);
        r = (m == 1'b0) ? -v : ((v < 0) ? -v : v);
        if (r > 127) begin
`ifdef TWOS_SAT_EN
            return 8'h7F;
`else
            return 8'h80;
`endif
        end
        return 8'(r);
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x, input logic m);
        int v;
        int r;
        v = $signed(x);
        r = (m == 1'b0) ? -v : ((v < 0) ? -v : v);
        return (r > 127);
    endfunction

    // Offer one operand, then wait (bounded) for the result; lat = -1 on timeout.
    task automatic start_op(input logic [W-1:0] x, input logic m, output int lat);
        int guard;
        guard = 0;
        while (bus.In_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.In_valid = 1'b1;
        bus.In       = x;
        bus.Mode     = m;
        @(posedge clk); #1;
        bus.In_valid = 1'b0;
        bus.In       = 8'($urandom);
        bus.Mode     = 1'($urandom);
        lat = 0;
        while (bus.Out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.Out_valid !== 1'b1) lat = -1;
    endtask

    task automatic finish_op();
        bus.Out_ready = 1'b1;
        @(posedge clk); #1;
        bus.Out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.In_valid  = 1'b0;
        bus.In        = '0;
        bus.Mode      = 1'b0;
        bus.Out_ready = 1'b0;
        #3;
        checks++;
        if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0 || bus.Out !== 8'h00 || bus.Ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: rdy=%b vld=%b out=%h ovf=%b want 1 0 00 0",
                     bus.In_ready, bus.Out_valid, bus.Out, bus.Ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] xs [7] = '{8'h05, 8'h80, 8'hFB, 8'h05, 8'h00, 8'h00, 8'h80};
        logic         ms [7] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
        int lat;
        for (int i = 0; i < 7; i++) begin
            start_op(xs[i], ms[i], lat);
            checks++;
            if (lat != 8) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d want 8", i, lat);
            end
            checks++;
            if (bus.Out !== model_out(xs[i], ms[i]) || bus.Ovf !== model_ovf(xs[i], ms[i])) begin
                failures++;
                $display("FAIL directed_result[%0d] in=%h mode=%b: got out=%h ovf=%b want out=%h ovf=%b",
                         i, xs[i], ms[i], bus.Out, bus.Ovf, model_out(xs[i], ms[i]), model_ovf(xs[i], ms[i]));
            end
            finish_op();
            checks++;
            if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0) begin
                failures++;
                $display("FAIL directed_release[%0d]: rdy=%b vld=%b want 1 0", i, bus.In_ready, bus.Out_valid);
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] exp_out;
        logic         exp_ovf;
        int lat;
        exp_out = model_out(8'hC3, 1'b0);
        exp_ovf = model_ovf(8'hC3, 1'b0);
        start_op(8'hC3, 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            bus.In_valid = 1'($urandom);
            bus.In       = 8'($urandom);
            bus.Mode     = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (bus.Out !== exp_out || bus.Ovf !== exp_ovf || bus.Out_valid !== 1'b1 || bus.In_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: out=%h ovf=%b vld=%b rdy=%b want %h %b 1 0",
                         c, bus.Out, bus.Ovf, bus.Out_valid, bus.In_ready, exp_out, exp_ovf);
            end
        end
        bus.In_valid = 1'b0;
        finish_op();
        start_op(8'h12, 1'b1, lat);
        checks++;
        if (lat != 8 || bus.Out !== 8'h12 || bus.Ovf !== 1'b0) begin
            failures++;
            $display("FAIL stall_next: lat=%0d out=%h ovf=%b want 8 12 0", lat, bus.Out, bus.Ovf);
        end
        finish_op();
    endtask

    task automatic test_reset_mid();
        int spurious;
        int lat;
        while (bus.In_ready !== 1'b1) begin @(posedge clk); #1; end
        bus.In_valid = 1'b1;
        bus.In       = 8'h6D;
        bus.Mode     = 1'b0;
        @(posedge clk); #1;
        bus.In_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #2;
        checks++;
        if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0 || bus.Out !== 8'h00 || bus.Ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: rdy=%b vld=%b out=%h ovf=%b want 1 0 00 0",
                     bus.In_ready, bus.Out_valid, bus.Out, bus.Ovf);
        end
        rst = 1'b0;
        spurious = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.Out_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL reset_mid_discard: out_valid seen %0d cycles want 0", spurious);
        end
        start_op(8'h01, 1'b0, lat);
        checks++;
        if (lat != 8 || bus.Out !== 8'hFF || bus.Ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_next: lat=%0d out=%h ovf=%b want 8 ff 0", lat, bus.Out, bus.Ovf);
        end
        finish_op();
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        logic [W-1:0] ops [N];
        logic         mds [N];
        logic [W-1:0] exp_out_q [$];
        logic         exp_ovf_q [$];
        logic [W-1:0] eo;
        logic         ev;
        int next_idx;
        int got;
        int last_acc;
        int cyc;
        logic acc;
        for (int i = 0; i < N; i++) begin
            ops[i] = (i == 2) ? 8'h80 : 8'($urandom);
            mds[i] = 1'($urandom);
        end
        while (bus.In_ready !== 1'b1) begin @(posedge clk); #1; end
        bus.Out_ready = 1'b1;
        bus.In_valid  = 1'b1;
        bus.In        = ops[0];
        bus.Mode      = mds[0];
        next_idx = 0;
        got      = 0;
        last_acc = -1;
        cyc      = 0;
        while (got < N && cyc < 150) begin
            acc = bus.In_valid && bus.In_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                exp_out_q.push_back(model_out(ops[next_idx], mds[next_idx]));
                exp_ovf_q.push_back(model_ovf(ops[next_idx], mds[next_idx]));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 10) begin
                        failures++;
                        $display("FAIL b2b_interval[%0d]: got %0d cycles want 10", next_idx, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                next_idx++;
                if (next_idx < N) begin
                    bus.In   = ops[next_idx];
                    bus.Mode = mds[next_idx];
                end else begin
                    bus.In_valid = 1'b0;
                end
            end
            if (bus.Out_valid === 1'b1) begin
                checks++;
                if (exp_out_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected: out=%h with no operand pending", bus.Out);
                end else begin
                    eo = exp_out_q.pop_front();
                    ev = exp_ovf_q.pop_front();
                    if (bus.Out !== eo || bus.Ovf !== ev) begin
                        failures++;
                        $display("FAIL b2b_result[%0d]: got out=%h ovf=%b want out=%h ovf=%b",
                                 got, bus.Out, bus.Ovf, eo, ev);
                    end
                end
                got++;
            end
        end
        checks++;
        if (got != N) begin
            failures++;
            $display("FAIL b2b_count: got %0d results want %0d", got, N);
        end
        bus.In_valid  = 1'b0;
        @(posedge clk); #1;
        bus.Out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] x;
        logic         m;
        int lat;
        int sel;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 7);
            x = (sel == 0) ? 8'h80 : (sel == 1) ? 8'h00 : 8'($urandom);
            m = 1'($urandom);
            start_op(x, m, lat);
            checks++;
            if (lat != 8 || bus.Out !== model_out(x, m) || bus.Ovf !== model_ovf(x, m)) begin
                failures++;
                $display("FAIL random[%0d] in=%h mode=%b: lat=%0d out=%h ovf=%b want 8 %h %b",
                         i, x, m, lat, bus.Out, bus.Ovf, model_out(x, m), model_ovf(x, m));
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            finish_op();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_twos_complementer.md
SERIAL_TWOS_COMPLEMENTER -- requirements
Module: serial_twos_complementer

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..64.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 In_valid  input  1  operand offered.
REQ-005 In_ready  output  1  block can accept an operand.
REQ-006 In  input  WIDTH  operand, two's-complement signed.
REQ-007 Mode  input  1  0 = negate, 1 = absolute value; sampled with In.
REQ-008 Out_valid  output  1  result available.
REQ-009 Out_ready  input  1  consumer accepts result.
REQ-010 Out  output  WIDTH  result.
REQ-011 Ovf  output  1  result not representable (most-negative input negated); qualified by Out_valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE: In_ready=1; on In_valid&In_ready, capture In, Mode, and MSB of In; clear bit counter and seen_one flag; go to SHIFT.
REQ-014 SHIFT: In_ready=0, Out_valid=0; one bit per cycle, LSB first.
REQ-015 Per-bit rule: invert_en = (Mode==0) | captured MSB; out bit = in bit when !invert_en or !seen_one, else inverted; seen_one sets after the first 1 bit.
REQ-016 After WIDTH SHIFT cycles go to DONE; Out_valid SHALL assert exactly WIDTH cycles after the accepting edge.
REQ-017 DONE: Out_valid=1, In_ready=0; Out and Ovf held stable until Out_ready=1, then go to IDLE on that edge.
REQ-018 No accept in the same cycle as the output handshake; sustained throughput is one operand per WIDTH+2 cycles.
REQ-019 Ovf=1 iff operand is 1 followed by WIDTH-1 zeros and invert_en=1; otherwise 0.
REQ-020 Zero operand SHALL produce Out=0, Ovf=0 in both modes.
REQ-021 Mode=1 with non-negative operand SHALL return the operand unchanged.
REQ-022 In and Mode changes outside the accepting cycle SHALL have no effect.

Reset
REQ-023 rst SHALL force IDLE immediately, independent of clk.
REQ-024 Reset values: In_ready=1, Out_valid=0, Out=0, Ovf=0; counter, seen_one and shift register cleared.
REQ-025 Reset during SHIFT or DONE SHALL discard the operation; no Out_valid follows.

Configuration
REQ-026 Macro TWOS_SAT_EN: when defined, an overflow result SHALL be WIDTH-bit max positive (0 then ones) with Ovf=1.
REQ-027 Without TWOS_SAT_EN, an overflow result SHALL wrap (1 then zeros) with Ovf=1; all other behaviour is identical.

Structure
REQ-028 Package twos_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and mode constants MODE_NEG=0, MODE_ABS=1.
REQ-029 One combinational sub-module twos_bit_cell SHALL implement REQ-015 (bit_in, seen_one, invert_en -> bit_out, seen_one_next).
REQ-030 Counter width SHALL be $clog2(WIDTH+1); no other arithmetic is needed.

Verification (WIDTH=8)
REQ-031 In=0x05, Mode=0, Out_ready=1 -> Out=0xFB, Ovf=0, Out_valid exactly 8 cycles after accept.
REQ-032 In=0x80, Mode=0 -> Ovf=1; Out=0x80 without TWOS_SAT_EN, 0x7F with it.
REQ-033 Mode=1: In=0xFB -> 0x05; In=0x05 -> 0x05; In=0x00 -> 0x00, Ovf=0.
REQ-034 Out_ready held 0 for 5 cycles in DONE -> Out, Ovf, Out_valid stable; In_ready=0; In_valid pulses ignored.
REQ-035 rst asserted mid-SHIFT (after bit 3) -> outputs at reset values without a clk edge; next operand 0x01 -> 0xFF.
REQ-036 Back-to-back operands with In_valid held high -> accepts every 10 cycles, all results correct.
